// File: rtl/reg_file_pkg.sv
// Shared sizing defaults and helpers for the reg_file_sb register store.
package reg_file_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned ByteW    = 8;

  // Ceiling log2, bounded loop so it stays elaboration-friendly.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_sb_word.sv
// One register-file entry: byte-enabled storage with synchronous active-low clear.
module reg_word
  import reg_file_pkg::*;
#(
  parameter  int unsigned WIDTH = DefWidth,
  localparam int unsigned NB    = WIDTH / ByteW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [NB-1:0]    be,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] word_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) word_q[i*ByteW +: ByteW] <= d[i*ByteW +: ByteW];
      end
    end
  end

  assign q = word_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with byte-enabled writes, write-to-read bypass and a busy scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int unsigned WIDTH = DefWidth,
  parameter  int unsigned DEPTH = DefDepth,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned NB    = WIDTH / ByteW,
  localparam int unsigned CW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [AW-1:0]    wr_addr,
  input  logic [NB-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wb_clr,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_busy_a,
  output logic             rd_busy_b,
  output logic [CW-1:0]    busy_cnt
);

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic wr_ok, clr_ok, lock_ok;
  assign wr_ok   = wen && (32'(wr_addr) < DEPTH);
  assign clr_ok  = wr_ok && wb_clr;
  assign lock_ok = lock_en && (32'(lock_addr) < DEPTH);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_word #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (wr_ok && (wr_addr == AW'(i))),
      .be   (wr_be),
      .d    (wr_data),
      .q    (word_q[i])
    );
  end

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];
  logic             rd_busy [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  // Out-of-range addresses match no entry, so they read as zero / not busy.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr[p] == AW'(i)) begin
          rd_data[p] = word_q[i];
          rd_busy[p] = busy_q[i];
        end
      end
      if (wr_ok && (wr_addr == rd_addr[p])) begin
        for (int l = 0; l < NB; l++) begin
          if (wr_be[l]) rd_data[p][l*ByteW +: ByteW] = wr_data[l*ByteW +: ByteW];
        end
        if (wb_clr) rd_busy[p] = 1'b0;
      end
      if (!rst_n) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign rd_busy_a = rd_busy[0];
  assign rd_busy_b = rd_busy[1];

  logic lock_new, clr_hit, same_addr;

  // Lock is applied after clear so a fresh producer supersedes the retiring one.
  always_comb begin
    busy_d   = busy_q;
    lock_new = 1'b0;
    clr_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_ok && (wr_addr == AW'(i))) begin
        clr_hit   = busy_q[i];
        busy_d[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (lock_ok && (lock_addr == AW'(i))) begin
        lock_new  = ~busy_q[i];
        busy_d[i] = 1'b1;
      end
    end
    same_addr = clr_ok && lock_ok && (wr_addr == lock_addr);
    cnt_d     = cnt_q + CW'(lock_new) - CW'(clr_hit && !same_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with per-byte write enables, write-to-read bypass and a per-entry busy scoreboard. It replaces the single-bit level-sensitive storage cell as the datapath's architectural register store: DEPTH entries of WIDTH bits, one write port, two read ports. The decode stage locks destination registers through the scoreboard and the writeback stage clears them. Default sizing is the ARMv4 integer register set of 16 × 32 bits.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of entries, 2..64; need not be a power of two.
- AW, $clog2(DEPTH), address width; derived, never overridden.
- NB, WIDTH/8, byte lanes; derived.
- CW, $clog2(DEPTH+1), busy-count width; derived.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wen  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_be  in  NB  byte-lane mask; bit i covers bits 8i+7:8i.
- wr_data  in  WIDTH  write data.
- wb_clr  in  1  with wen, clears busy[wr_addr].
- lock_en  in  1  sets busy[lock_addr].
- lock_addr  in  AW  entry to lock.
- rd_addr_a, rd_addr_b  in  AW  read addresses.
- rd_data_a, rd_data_b  out  WIDTH  read data, combinational.
- rd_busy_a, rd_busy_b  out  1  busy status of the addressed entry, combinational.
- busy_cnt  out  CW  registered count of busy entries.

## Operation
- Reset, sampled at the clk edge while rst_n=0: all entries go to 0, all busy bits go to 0, busy_cnt goes to 0. While rst_n=0, rd_data_* and rd_busy_* are forced to 0, and wen and lock_en are ignored.
- Write: at the edge with wen=1, entry[wr_addr] takes wr_data in the lanes where wr_be=1. Other lanes hold their value. wr_be=0 gives a no-op write, but wb_clr still acts.
- Read: rd_data_x = entry[rd_addr_x], merged with the bypass.
  - Bypass: if wen=1 and wr_addr=rd_addr_x, lanes with wr_be=1 show wr_data and the remaining lanes show the stored value.
  - Both ports may read the same address.
- Scoreboard:
  - rd_busy_x = busy[rd_addr_x] & ~(wen & wb_clr & wr_addr==rd_addr_x). A clear is visible in the same cycle.
  - A lock becomes visible the cycle after lock_en.
  - Lock and clear on the same address in the same cycle: the lock wins and busy stays 1, because the new producer supersedes the old one.
  - Locking an already-busy entry leaves it 1 and busy_cnt is unchanged.
  - Clearing a non-busy entry is a no-op.
- busy_cnt: next value = current value + (lock sets a 0 bit) − (clear resets a 1 bit). It equals popcount(busy) every cycle and never wraps.
- Out-of-range address (≥ DEPTH):
  - Write, lock and clear are ignored.
  - Reads return data 0 and busy 0.
  - No bypass applies from an out-of-range write.

## Timing
- Read latency is 0 cycles, combinational from address and from the write-port inputs.
- Write, lock and clear take effect at the next rising clk edge.
- busy_cnt changes one cycle after the lock or clear.
- There are no handshakes and no stalls; the port is always ready.
- Reset asserted mid-operation discards any write, lock or clear presented in the same cycle.

## Structure
- Package reg_file_pkg holds:
  - default WIDTH, DEPTH;
  - byte-lane constant 8;
  - function clog2 for the derived widths.
- Sub-module reg_word: one WIDTH-bit edge-triggered register with NB byte enables and synchronous active-low clear. It is instantiated DEPTH times.
- Top level holds the read muxes with bypass merge, the busy vector and the busy_cnt update.

## Test plan
- Reset, then write 0xDEADBEEF to r3 with wr_be=1111. Next cycle rd_addr_a=3 → rd_data_a=0xDEADBEEF.
- r5=0x11223344 stored; write 0xAABBCCDD, wr_be=0101, while reading r5 in the same cycle → 0x11BB33DD on both ports, and stored value 0x11BB33DD afterwards.
- lock_en with lock_addr=7 → next cycle rd_busy_a=1, busy_cnt=1. Then wen with wb_clr, wr_addr=7 → rd_busy_a=0 in that cycle, busy_cnt=0 one cycle later.
- Lock and clear r2 in the same cycle with r2 already busy → busy[2]=1 and busy_cnt unchanged.
- DEPTH=13: write to address 14, lock address 15, read address 14 → rd_data=0, rd_busy=0, busy_cnt unchanged.
- Lock r0..r15 over 16 cycles (busy_cnt=16), then pull rst_n low mid-write of r9 → all outputs 0 after the edge and r9 reads 0.
